// File: rtl/entry_ctrl_pkg.sv
// Shared types and sizes for the hex operand entry controller.
package entry_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int OP_W       = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-FF synchronizer -> optional debouncer -> one-cycle press pulse.
// Debounce stage is built only when ENTRY_DEBOUNCE_EN is defined.
module button_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic bttn_raw,
    output logic press_p
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bttn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef ENTRY_DEBOUNCE_EN
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        db_q;
    logic        db_d;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign level = db_q;
`else
    // Debounce length is meaningless without the counter; keep the parameter referenced.
    if (DEBOUNCE_CYCLES == 20'd0) begin : g_no_debounce_cfg
    end

    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign press_p = level & ~prev_q;

endmodule

// File: rtl/nibble_entry_ctrl.sv
// Two-operand hex entry controller driving an external 4-nibble shift register.
// Optional button debounce: define ENTRY_DEBOUNCE_EN.
module nibble_entry_ctrl
    import entry_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bttn_shift,
    input  logic               bttn_enter,
    input  logic               bttn_clear,
    input  logic [DIGIT_W-1:0] sw_in,
    input  logic [OP_W-1:0]    dato,
    output logic               shift_en,
    output logic [DIGIT_W-1:0] nibble_out,
    output logic               sr_rst,
    output logic [OP_W-1:0]    op_a,
    output logic [OP_W-1:0]    op_b,
    output logic               ops_valid,
    output logic [CNT_W-1:0]   digit_cnt,
    output logic [1:0]         state_o
);

    logic sft_p;
    logic ent_p;
    logic clr_p;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_shift (
        .clk(clk), .rst(rst), .bttn_raw(bttn_shift), .press_p(sft_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_enter (
        .clk(clk), .rst(rst), .bttn_raw(bttn_enter), .press_p(ent_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clear (
        .clk(clk), .rst(rst), .bttn_raw(bttn_clear), .press_p(clr_p)
    );

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [OP_W-1:0]    op_a_q,      op_a_d;
    logic [OP_W-1:0]    op_b_q,      op_b_d;
    logic               ops_valid_q, ops_valid_d;
    logic               shift_en_q,  shift_en_d;
    logic [DIGIT_W-1:0] nibble_q,    nibble_d;
    logic               sr_pulse_q,  sr_pulse_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ops_valid_d = ops_valid_q;
        shift_en_d  = 1'b0;
        nibble_d    = nibble_q;
        sr_pulse_d  = 1'b0;

        // Priority clear > enter > shift; losers are simply dropped.
        if (clr_p) begin
            sr_pulse_d  = 1'b1;
            digit_cnt_d = '0;
            if (state_q == DONE) begin
                op_a_d      = '0;
                op_b_d      = '0;
                ops_valid_d = 1'b0;
                state_d     = ENTRY_A;
            end
        end else if (ent_p) begin
            case (state_q)
                ENTRY_A: begin
                    if (digit_cnt_q != '0) begin
                        op_a_d      = dato;
                        sr_pulse_d  = 1'b1;
                        digit_cnt_d = '0;
                        state_d     = ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (digit_cnt_q != '0) begin
                        op_b_d      = dato;
                        sr_pulse_d  = 1'b1;
                        digit_cnt_d = '0;
                        ops_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                default: begin
                    ops_valid_d = 1'b0;
                    state_d     = ENTRY_A;
                end
            endcase
        end else if (sft_p) begin
            if (state_q != DONE && digit_cnt_q < CNT_W'(NUM_DIGITS)) begin
                shift_en_d  = 1'b1;
                nibble_d    = sw_in;
                digit_cnt_d = digit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTRY_A;
            digit_cnt_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ops_valid_q <= 1'b0;
            shift_en_q  <= 1'b0;
            nibble_q    <= '0;
            sr_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ops_valid_q <= ops_valid_d;
            shift_en_q  <= shift_en_d;
            nibble_q    <= nibble_d;
            sr_pulse_q  <= sr_pulse_d;
        end
    end

    // The shift register is cleared for the whole reset, not just after it.
    assign sr_rst     = sr_pulse_q | rst;
    assign shift_en   = shift_en_q;
    assign nibble_out = nibble_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign ops_valid  = ops_valid_q;
    assign digit_cnt  = digit_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_nibble_entry_ctrl.sv
// Directed self-checking bench for nibble_entry_ctrl; debounce checks run when
// ENTRY_DEBOUNCE_EN is defined (DEBOUNCE_CYCLES forced to 8).
module tb_nibble_entry_ctrl;
    import entry_ctrl_pkg::*;

`ifdef ENTRY_DEBOUNCE_EN
    localparam int HOLD = 12;
    localparam int GAP  = 14;
`else
    localparam int HOLD = 2;
    localparam int GAP  = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bttn_shift, bttn_enter, bttn_clear;
    logic [3:0]  sw_in;
    logic [15:0] dato;
    logic        shift_en;
    logic [3:0]  nibble_out;
    logic        sr_rst;
    logic [15:0] op_a, op_b;
    logic        ops_valid;
    logic [2:0]  digit_cnt;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    int shift_cnt = 0;
    int sr_cnt    = 0;
    int both_cnt  = 0;
    logic [3:0] nib_log[$];

    always #5 clk = ~clk;

    nibble_entry_ctrl #(.DEBOUNCE_CYCLES(20'd8)) dut (
        .clk(clk), .rst(rst),
        .bttn_shift(bttn_shift), .bttn_enter(bttn_enter), .bttn_clear(bttn_clear),
        .sw_in(sw_in), .dato(dato),
        .shift_en(shift_en), .nibble_out(nibble_out), .sr_rst(sr_rst),
        .op_a(op_a), .op_b(op_b), .ops_valid(ops_valid),
        .digit_cnt(digit_cnt), .state_o(state_o)
    );

    always @(negedge clk) begin
        if (shift_en) begin
            shift_cnt++;
            nib_log.push_back(nibble_out);
        end
        if (sr_rst && !rst) sr_cnt++;
        if (shift_en && sr_rst) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic s, input logic e, input logic c, input int hold);
        bttn_shift = s;
        bttn_enter = e;
        bttn_clear = c;
        repeat (hold) @(negedge clk);
        bttn_shift = 1'b0;
        bttn_enter = 1'b0;
        bttn_clear = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(ENTRY_A));
        check({tag, "_cnt"},   32'(digit_cnt), 32'd0);
        check({tag, "_op_a"},  32'(op_a), 32'd0);
        check({tag, "_op_b"},  32'(op_b), 32'd0);
        check({tag, "_valid"}, 32'(ops_valid), 32'd0);
        check({tag, "_shen"},  32'(shift_en), 32'd0);
        check({tag, "_nib"},   32'(nibble_out), 32'd0);
        check({tag, "_srrst"}, 32'(sr_rst), 32'd1);
    endtask

    int s0, r0, nb;

    initial begin
        rst = 1'b1;
        bttn_shift = 1'b0; bttn_enter = 1'b0; bttn_clear = 1'b0;
        sw_in = 4'h0; dato = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("srrst_release", 32'(sr_rst), 32'd0);

        // Five shift presses with sw_in = 1..5: only four accepted.
        s0 = shift_cnt;
        nb = nib_log.size();
`ifdef ENTRY_DEBOUNCE_EN
        sw_in = 4'h1;
        press(1'b1, 1'b0, 1'b0, HOLD);
`else
        sw_in = 4'h1;
        bttn_shift = 1'b1;
        @(negedge clk);
        check("lat_edge1", 32'(shift_en), 32'd0);
        @(negedge clk);
        check("lat_edge2", 32'(shift_en), 32'd0);
        @(negedge clk);
        check("lat_edge3", 32'(shift_en), 32'd1);
        check("lat_nib",   32'(nibble_out), 32'h1);
        check("lat_cnt",   32'(digit_cnt), 32'd1);
        bttn_shift = 1'b0;
        repeat (GAP) @(negedge clk);
`endif
        for (int i = 2; i <= 5; i++) begin
            sw_in = 4'(i);
            press(1'b1, 1'b0, 1'b0, HOLD);
        end
        check("shift4_pulses", 32'(shift_cnt - s0), 32'd4);
        for (int j = 0; j < 4; j++)
            check("shift4_nib", (nb + j < nib_log.size()) ? 32'(nib_log[nb + j]) : 32'hFFFF_FFFF,
                  32'(j + 1));
        check("shift4_cnt", 32'(digit_cnt), 32'd4);

        // Clear back to an empty entry, then an empty enter is ignored.
        r0 = sr_cnt;
        press(1'b0, 1'b0, 1'b1, HOLD);
        check("clrA_sr", 32'(sr_cnt - r0), 32'd1);
        check("clrA_cnt", 32'(digit_cnt), 32'd0);
        r0 = sr_cnt;
        press(1'b0, 1'b1, 1'b0, HOLD);
        check("ent0_state", 32'(state_o), 32'(ENTRY_A));
        check("ent0_sr", 32'(sr_cnt - r0), 32'd0);
        check("ent0_op_a", 32'(op_a), 32'h0);

        // Two digits then enter commits op_a.
        sw_in = 4'hA; press(1'b1, 1'b0, 1'b0, HOLD);
        sw_in = 4'hB; press(1'b1, 1'b0, 1'b0, HOLD);
        check("two_cnt", 32'(digit_cnt), 32'd2);
        dato = 16'h00AB;
        r0 = sr_cnt;
        press(1'b0, 1'b1, 1'b0, HOLD);
        check("entA_op_a", 32'(op_a), 32'h00AB);
        check("entA_sr", 32'(sr_cnt - r0), 32'd1);
        check("entA_state", 32'(state_o), 32'(ENTRY_B));
        check("entA_cnt", 32'(digit_cnt), 32'd0);

        // Commit op_b, then enter from DONE returns to ENTRY_A.
        sw_in = 4'h4; press(1'b1, 1'b0, 1'b0, HOLD);
        dato = 16'h1234;
        press(1'b0, 1'b1, 1'b0, HOLD);
        check("entB_op_b", 32'(op_b), 32'h1234);
        check("entB_valid", 32'(ops_valid), 32'd1);
        check("entB_state", 32'(state_o), 32'(DONE));
        press(1'b0, 1'b1, 1'b0, HOLD);
        check("done_valid", 32'(ops_valid), 32'd0);
        check("done_state", 32'(state_o), 32'(ENTRY_A));
        check("done_op_a", 32'(op_a), 32'h00AB);
        check("done_op_b", 32'(op_b), 32'h1234);

        // Simultaneous clear/enter/shift: clear wins.
        sw_in = 4'h7; press(1'b1, 1'b0, 1'b0, HOLD);
        dato = 16'hBEEF;
        s0 = shift_cnt;
        r0 = sr_cnt;
        press(1'b1, 1'b1, 1'b1, HOLD);
        check("all3_sr", 32'(sr_cnt - r0), 32'd1);
        check("all3_shift", 32'(shift_cnt - s0), 32'd0);
        check("all3_op_a", 32'(op_a), 32'h00AB);
        check("all3_op_b", 32'(op_b), 32'h1234);
        check("all3_cnt", 32'(digit_cnt), 32'd0);
        check("all3_state", 32'(state_o), 32'(ENTRY_A));

        // Clear in ENTRY_B keeps op_a; clear in DONE wipes everything.
        sw_in = 4'h5; press(1'b1, 1'b0, 1'b0, HOLD);
        dato = 16'h5555; press(1'b0, 1'b1, 1'b0, HOLD);
        sw_in = 4'h6; press(1'b1, 1'b0, 1'b0, HOLD);
        press(1'b0, 1'b0, 1'b1, HOLD);
        check("clrB_state", 32'(state_o), 32'(ENTRY_B));
        check("clrB_op_a", 32'(op_a), 32'h5555);
        check("clrB_cnt", 32'(digit_cnt), 32'd0);
        sw_in = 4'h8; press(1'b1, 1'b0, 1'b0, HOLD);
        dato = 16'h7777; press(1'b0, 1'b1, 1'b0, HOLD);
        check("preclr_state", 32'(state_o), 32'(DONE));
        press(1'b0, 1'b0, 1'b1, HOLD);
        check("clrD_state", 32'(state_o), 32'(ENTRY_A));
        check("clrD_op_a", 32'(op_a), 32'h0);
        check("clrD_op_b", 32'(op_b), 32'h0);
        check("clrD_valid", 32'(ops_valid), 32'd0);

        // A long hold produces a single shift.
        s0 = shift_cnt;
        sw_in = 4'h9;
        press(1'b1, 1'b0, 1'b0, 100);
        check("hold_shift", 32'(shift_cnt - s0), 32'd1);
        check("hold_nib", 32'(nibble_out), 32'h9);

        // Reset mid-entry with a press in flight.
        s0 = shift_cnt;
        bttn_shift = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        bttn_shift = 1'b0;
        rst = 1'b0;
        repeat (GAP) @(negedge clk);
        check("midrst_noshift", 32'(shift_cnt - s0), 32'd0);
        check("midrst_cnt", 32'(digit_cnt), 32'd0);

`ifdef ENTRY_DEBOUNCE_EN
        // A 5-cycle glitch is filtered, an 8+ cycle press is accepted once.
        s0 = shift_cnt;
        sw_in = 4'h3;
        press(1'b1, 1'b0, 1'b0, 5);
        check("db_glitch", 32'(shift_cnt - s0), 32'd0);
        press(1'b1, 1'b0, 1'b0, 10);
        check("db_stable", 32'(shift_cnt - s0), 32'd1);
        check("db_nib", 32'(nibble_out), 32'h3);
`endif

        check("no_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_entry_ctrl.md
NIBBLE_ENTRY_CTRL -- requirements
Module: nibble_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000: stable-cycle count for button debounce when ENTRY_DEBOUNCE_EN is defined.
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bttn_shift  input  1  raw push button: append one hex digit.
REQ-005 bttn_enter  input  1  raw push button: commit the current 16-bit entry as an operand.
REQ-006 bttn_clear  input  1  raw push button: discard the current entry.
REQ-007 sw_in  input  4  hex digit from switches.
REQ-008 dato  input  16  current value of the external 4-nibble shift register.
REQ-009 shift_en  output  1  one-cycle enable to the shift register.
REQ-010 nibble_out  output  4  digit presented to the shift register data input.
REQ-011 sr_rst  output  1  clear to the shift register.
REQ-012 op_a, op_b  output  16 each  committed operands.
REQ-013 ops_valid  output  1  both operands committed.
REQ-014 digit_cnt  output  3  digits entered in the current entry, 0..4.
REQ-015 state_o  output  2  current FSM state, encoded per package enum.

Function
REQ-016 The FSM SHALL have states ENTRY_A, ENTRY_B and DONE.
REQ-017 Each button SHALL pass through a 2-FF synchronizer and a rising-edge detector yielding a one-cycle press pulse per physical press; a held button SHALL NOT repeat.
REQ-018 nibble_out SHALL equal sw_in registered on the same edge that asserts shift_en.
REQ-019 A shift press in ENTRY_A/ENTRY_B with digit_cnt<4 SHALL assert shift_en for exactly one cycle and increment digit_cnt; with digit_cnt==4 or in DONE it SHALL be ignored.
REQ-020 Without debounce, shift_en SHALL assert on the 3rd rising clk edge after the first edge sampling bttn_shift high.
REQ-021 An enter press in ENTRY_A with digit_cnt>0 SHALL load op_a<=dato, pulse sr_rst one cycle, clear digit_cnt and move to ENTRY_B; with digit_cnt==0 it SHALL be ignored.
REQ-022 An enter press in ENTRY_B with digit_cnt>0 SHALL load op_b<=dato, pulse sr_rst, clear digit_cnt, set ops_valid and move to DONE.
REQ-023 An enter press in DONE SHALL clear ops_valid and move to ENTRY_A; op_a/op_b SHALL hold until overwritten.
REQ-024 A clear press SHALL pulse sr_rst and zero digit_cnt in any state; in ENTRY_B it SHALL keep op_a and stay in ENTRY_B; in DONE it SHALL zero op_a, op_b, ops_valid and move to ENTRY_A.
REQ-025 Press pulses coinciding in one cycle SHALL resolve clear > enter > shift; lower-priority pulses SHALL be dropped, not queued.
REQ-026 shift_en and sr_rst SHALL never be high in the same cycle.

Reset
REQ-027 While rst is high: state ENTRY_A, digit_cnt 0, op_a/op_b 0, ops_valid 0, shift_en 0, nibble_out 0, synchronizer and edge detector flops 0, debounce counters 0.
REQ-028 sr_rst SHALL be high in every cycle rst is high (combinational OR with the internal pulse).
REQ-029 Reset asserted mid-entry SHALL discard any pending press pulse.

Configuration
REQ-030 With ENTRY_DEBOUNCE_EN defined, each synchronized button SHALL change its debounced level only after DEBOUNCE_CYCLES consecutive equal samples, the edge detector following the debounced level, adding DEBOUNCE_CYCLES cycles of latency.
REQ-031 Without ENTRY_DEBOUNCE_EN, no debounce counter SHALL be synthesized, and REQ-020 latency applies.

Structure
REQ-032 Package entry_ctrl_pkg SHALL hold the state enum (2 bits), NUM_DIGITS=4 and DIGIT_W=4.
REQ-033 Synchronizer, optional debouncer and edge detector SHALL be one sub-module, button_conditioner, instantiated three times.

Verification (ENTRY_DEBOUNCE_EN undefined unless stated)
REQ-034 Reset, then shift presses with sw_in=1,2,3,4,5 -> four shift_en pulses, nibble_out 1..4 on them, digit_cnt=4, fifth press ignored.
REQ-035 Enter with digit_cnt=0 in ENTRY_A -> no change; then 2 shifts, dato=16'h00AB, enter -> op_a=16'h00AB, one sr_rst pulse, state ENTRY_B.
REQ-036 In ENTRY_B, dato=16'h1234, enter -> op_b=16'h1234, ops_valid=1, DONE; enter again -> ops_valid=0, ENTRY_A, op_a=16'h00AB retained.
REQ-037 Clear, enter and shift pulses in the same cycle -> only sr_rst, no shift_en, op regs unchanged, digit_cnt=0.
REQ-038 bttn_shift held high 100 cycles -> exactly one shift_en; rst mid-entry -> all outputs at reset values, sr_rst high.
REQ-039 ENTRY_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=8: 5-cycle glitch -> no shift_en; 8-cycle stable press -> one shift_en.
